// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate decoder feeding a 2-entry valid/ready FIFO.
// Immediates are decoded when a request is accepted. Each stored entry carries
// the extended immediate, a sideband tag and an illegal-format flag.
module imm_extend_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      Instr,
   input  logic [2:0]       ImmSrc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  ImmExt,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   typedef enum logic [2:0] {
      IMM_I     = 3'b000,
      IMM_S     = 3'b001,
      IMM_B     = 3'b010,
      IMM_J     = 3'b011,
      IMM_U     = 3'b100,
      IMM_SHAMT = 3'b101,
      IMM_ZIMM  = 3'b110,
      IMM_BAD   = 3'b111
   } imm_src_e;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } entry_t;

   imm_src_e   src_e;
   logic [63:0] imm64;
   logic        dec_illegal;
   entry_t      wr_entry;
   entry_t      head;

   entry_t      mem_q [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   logic        accept;
   logic        pop;

   // Opcode bits never feed any immediate; upper decode bits drop out at XLEN=32.
   logic        unused_bits;
   assign unused_bits = ^{Instr[6:0], imm64};

   assign src_e = imm_src_e'(ImmSrc);

   // Decode to a full 64-bit value; narrowing to XLEN yields the 32-bit forms,
   // including U-type, whose upper word only matters at XLEN=64.
   always_comb begin
      imm64       = '0;
      dec_illegal = 1'b0;
      case (src_e)
         IMM_I:     imm64 = {{52{Instr[31]}}, Instr[31:20]};
         IMM_S:     imm64 = {{52{Instr[31]}}, Instr[31:25], Instr[11:7]};
         IMM_B:     imm64 = {{52{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
         IMM_J:     imm64 = {{44{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
         IMM_U:     imm64 = {{32{Instr[31]}}, Instr[31:12], 12'b0};
         IMM_SHAMT: imm64 = (XLEN == 64) ? {58'b0, Instr[25:20]} : {59'b0, Instr[24:20]};
         IMM_ZIMM:  imm64 = {59'b0, Instr[19:15]};
         default:   dec_illegal = 1'b1;
      endcase
   end

   // Pack the entry written on accept.
   always_comb begin
      wr_entry.imm     = imm64[XLEN-1:0];
      wr_entry.tag     = in_tag;
      wr_entry.illegal = dec_illegal;
   end

   // Handshake flags come from registered occupancy only.
   assign in_ready  = (count_q < 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Occupancy and pointer next-state.
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (accept) wr_ptr_d = ~wr_ptr_q;
      if (pop)    rd_ptr_d = ~rd_ptr_q;
   end

   // FIFO state; reset overrides any same-cycle accept or pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (accept) mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   // Present the head entry; outputs read zero while empty so no stale slot leaks out.
   always_comb begin
      head        = mem_q[rd_ptr_q];
      ImmExt      = out_valid ? head.imm     : '0;
      out_tag     = out_valid ? head.tag     : '0;
      out_illegal = out_valid ? head.illegal : 1'b0;
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: directed scenarios plus randomized traffic
// checked against an arithmetic decode model and a queue-based FIFO model.
module tb_imm_extend_pipe;

   logic        clk;
   logic        reset;

   logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0] instr;
   logic [2:0]  imm_src;
   logic [4:0]  in_tag, out_tag;
   logic [31:0] imm_ext;

   logic        s64_in_valid, s64_in_ready, s64_out_valid, s64_out_ready, s64_out_illegal;
   logic [31:0] s64_instr;
   logic [2:0]  s64_imm_src;
   logic [4:0]  s64_in_tag, s64_out_tag;
   logic [63:0] s64_imm_ext;

   int checks = 0;
   int errors = 0;

   imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .Instr(instr), .ImmSrc(imm_src), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .ImmExt(imm_ext), .out_tag(out_tag), .out_illegal(out_illegal)
   );

   imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
      .clk(clk), .reset(reset), .in_valid(s64_in_valid), .in_ready(s64_in_ready),
      .Instr(s64_instr), .ImmSrc(s64_imm_src), .in_tag(s64_in_tag), .out_valid(s64_out_valid),
      .out_ready(s64_out_ready), .ImmExt(s64_imm_ext), .out_tag(s64_out_tag),
      .out_illegal(s64_out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and land just after the edge, where outputs are settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint sext(input longint unsigned f, input int n);
      if (f >= (longint'(1) << (n - 1))) return longint'(f) - (longint'(1) << n);
      return longint'(f);
   endfunction

   // Reference decode from field values and signed arithmetic.
   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                           input int xlen);
      longint v;
      longint unsigned f;
      case (src)
         3'd0: v = sext(64'(ins[31:20]), 12);
         3'd1: begin f = 64'(ins[31:25]) * 32 + 64'(ins[11:7]); v = sext(f, 12); end
         3'd2: begin
            f = 64'(ins[31]) * 4096 + 64'(ins[7]) * 2048 + 64'(ins[30:25]) * 32 + 64'(ins[11:8]) * 2;
            v = sext(f, 13);
         end
         3'd3: begin
            f = 64'(ins[31]) * (64'd1 << 20) + 64'(ins[19:12]) * 4096 + 64'(ins[20]) * 2048
                + 64'(ins[30:21]) * 2;
            v = sext(f, 21);
         end
         3'd4: v = sext(64'(ins[31:12]) * 4096, 32);
         3'd5: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
         3'd6: v = longint'(ins[19:15]);
         default: v = 0;
      endcase
      if (xlen == 32) return {32'b0, v[31:0]};
      return v;
   endfunction

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      instr = 32'hFFF00093; imm_src = 3'd0; in_tag = 5'd9;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm_ext !== 32'h0 ||
          out_tag !== 5'd0 || out_illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b ready=%b imm=%h tag=%0d ill=%b, want 0 1 0 0 0",
                  out_valid, in_ready, imm_ext, out_tag, out_illegal);
      end
      checks++;
      if (s64_out_valid !== 1'b0 || s64_in_ready !== 1'b1 || s64_imm_ext !== 64'h0) begin
         errors++;
         $display("FAIL reset_state64: valid=%b ready=%b imm=%h, want 0 1 0",
                  s64_out_valid, s64_in_ready, s64_imm_ext);
      end
      reset = 1'b0; in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_decode_sweep();
      logic [31:0] vi [4] = '{32'hFFF00093, 32'hFE112E23, 32'h01F09093, 32'h000FD073};
      logic [2:0]  vs [4] = '{3'd0, 3'd1, 3'd5, 3'd6};
      logic [31:0] ve [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0000001F, 32'h0000001F};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; instr = vi[i]; imm_src = vs[i]; in_tag = 5'(i + 4);
         tick();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || imm_ext !== ve[i] || out_tag !== 5'(i + 4) || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL decode_vec%0d: valid=%b imm=%h tag=%0d ill=%b, want 1 %h %0d 0",
                     i, out_valid, imm_ext, out_tag, out_illegal, ve[i], i + 4);
         end
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_drain%0d: valid=%b, want 0", i, out_valid);
         end
      end
   endtask

   task automatic test_decode_random();
      logic [63:0] e32, e64;
      out_ready = 1'b1; s64_out_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         instr = $urandom; imm_src = 3'($urandom_range(0, 7)); in_tag = 5'($urandom);
         s64_instr = instr; s64_imm_src = imm_src; s64_in_tag = in_tag;
         in_valid = 1'b1; s64_in_valid = 1'b1;
         e32 = ref_imm(instr, imm_src, 32);
         e64 = ref_imm(instr, imm_src, 64);
         tick();
         in_valid = 1'b0; s64_in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || imm_ext !== e32[31:0] || out_tag !== in_tag ||
             out_illegal !== (imm_src == 3'd7)) begin
            errors++;
            $display("FAIL rand32: instr=%h src=%0d imm=%h ill=%b, want %h %b",
                     instr, imm_src, imm_ext, out_illegal, e32[31:0], imm_src == 3'd7);
         end
         checks++;
         if (s64_out_valid !== 1'b1 || s64_imm_ext !== e64 || s64_out_tag !== in_tag ||
             s64_out_illegal !== (imm_src == 3'd7)) begin
            errors++;
            $display("FAIL rand64: instr=%h src=%0d imm=%h ill=%b, want %h %b",
                     instr, imm_src, s64_imm_ext, s64_out_illegal, e64, imm_src == 3'd7);
         end
         tick();
      end
   endtask

   task automatic test_u64();
      logic [31:0] vi [2] = '{32'h123452B7, 32'h800002B7};
      logic [63:0] ve [2] = '{64'h0000000012345000, 64'hFFFFFFFF80000000};
      s64_out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         s64_in_valid = 1'b1; s64_instr = vi[i]; s64_imm_src = 3'd4; s64_in_tag = 5'(i);
         tick();
         s64_in_valid = 1'b0;
         checks++;
         if (s64_out_valid !== 1'b1 || s64_imm_ext !== ve[i] || s64_out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL u64_vec%0d: valid=%b imm=%h, want 1 %h", i, s64_out_valid, s64_imm_ext, ve[i]);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; imm_src = 3'd0;
      for (int t = 1; t <= 3; t++) begin
         in_valid = 1'b1; in_tag = 5'(t); instr = {12'(t * 3), 20'h00093};
         checks++;
         if (in_ready !== (t < 3)) begin
            errors++;
            $display("FAIL bp_ready_t%0d: in_ready=%b, want %b", t, in_ready, t < 3);
         end
         tick();
      end
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1 || imm_ext !== 32'd3) begin
            errors++;
            $display("FAIL bp_stall%0d: ready=%b valid=%b tag=%0d imm=%h, want 0 1 1 3",
                     c, in_ready, out_valid, out_tag, imm_ext);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 5'd2 || imm_ext !== 32'd6 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_drain2: valid=%b tag=%0d imm=%h ready=%b, want 1 2 6 1",
                  out_valid, out_tag, imm_ext, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 5'd3 || imm_ext !== 32'd9) begin
         errors++;
         $display("FAIL bp_drain3: valid=%b tag=%0d imm=%h, want 1 3 9", out_valid, out_tag, imm_ext);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_streaming();
      logic [63:0] e;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_tag = 5'(10 + i);
         instr = $urandom; imm_src = 3'($urandom_range(0, 6));
         e = ref_imm(instr, imm_src, 32);
         tick();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_tag !== 5'(10 + i) || imm_ext !== e[31:0]) begin
            errors++;
            $display("FAIL stream%0d: valid=%b ready=%b tag=%0d imm=%h, want 1 1 %0d %h",
                     i, out_valid, in_ready, out_tag, imm_ext, 10 + i, e[31:0]);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_end: valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_illegal_reset();
      out_ready = 1'b1; in_valid = 1'b1; instr = $urandom | 32'hFFF00000; imm_src = 3'd7; in_tag = 5'd21;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || imm_ext !== 32'h0 || out_illegal !== 1'b1 || out_tag !== 5'd21) begin
         errors++;
         $display("FAIL illegal: valid=%b imm=%h ill=%b tag=%0d, want 1 0 1 21",
                  out_valid, imm_ext, out_illegal, out_tag);
      end
      tick();
      out_ready = 1'b0; imm_src = 3'd0; instr = 32'h00500093;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_tag = 5'(25 + i);
         tick();
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL fill_full: ready=%b valid=%b, want 0 1", in_ready, out_valid);
      end
      reset = 1'b1; out_ready = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm_ext !== 32'h0 || out_tag !== 5'd0) begin
         errors++;
         $display("FAIL midstall_reset: valid=%b ready=%b imm=%h tag=%0d, want 0 1 0 0",
                  out_valid, in_ready, imm_ext, out_tag);
      end
      in_valid = 1'b1; in_tag = 5'd30; instr = 32'h07B00093;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 5'd30 || imm_ext !== 32'd123) begin
         errors++;
         $display("FAIL post_reset_accept: valid=%b tag=%0d imm=%h, want 1 30 7b", out_valid, out_tag, imm_ext);
      end
      tick();
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_entry%0d: valid=%b tag=%0d, want 0", c, out_valid, out_tag);
         end
         tick();
      end
   endtask

   task automatic test_random_traffic();
      logic [63:0] q_imm [$];
      logic [4:0]  q_tag [$];
      logic        q_ill [$];
      logic [63:0] e;
      bit acc, pp, exp_v, exp_r;
      for (int c = 0; c < 400; c++) begin
         exp_v = (q_tag.size() > 0);
         exp_r = (q_tag.size() < 2);
         checks++;
         if (out_valid !== exp_v || in_ready !== exp_r) begin
            errors++;
            $display("FAIL rt_flags@%0d: valid=%b ready=%b, want %b %b", c, out_valid, in_ready, exp_v, exp_r);
         end
         if (exp_v) begin
            checks++;
            if (imm_ext !== q_imm[0][31:0] || out_tag !== q_tag[0] || out_illegal !== q_ill[0]) begin
               errors++;
               $display("FAIL rt_head@%0d: imm=%h tag=%0d ill=%b, want %h %0d %b",
                        c, imm_ext, out_tag, out_illegal, q_imm[0][31:0], q_tag[0], q_ill[0]);
            end
         end
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         instr = $urandom; imm_src = 3'($urandom_range(0, 7)); in_tag = 5'($urandom);
         e = ref_imm(instr, imm_src, 32);
         acc = in_valid && (q_tag.size() < 2);
         pp = out_ready && (q_tag.size() > 0);
         tick();
         if (pp) begin
            void'(q_imm.pop_front()); void'(q_tag.pop_front()); void'(q_ill.pop_front());
         end
         if (acc) begin
            q_imm.push_back(e); q_tag.push_back(in_tag); q_ill.push_back(imm_src == 3'd7);
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0; imm_src = '0; in_tag = '0;
      s64_in_valid = 1'b0; s64_out_ready = 1'b1; s64_instr = '0; s64_imm_src = '0; s64_in_tag = '0;
      test_reset();
      test_decode_sweep();
      test_u64();
      test_decode_random();
      test_backpressure();
      test_streaming();
      test_illegal_reset();
      test_random_traffic();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
